// File: rtl/r2sdf_stage.sv
// Radix-2 single-path delay-feedback butterfly stage driving an external DEPTH-cycle delay line.
// Define R2SDF_SAT_EN for saturating arithmetic with a sticky ovf flag; the default build wraps.
module r2sdf_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_re,
  input  logic [DATA_WIDTH-1:0] in_im,
  input  logic [DATA_WIDTH-1:0] dly_out_re,
  input  logic [DATA_WIDTH-1:0] dly_out_im,
  output logic [DATA_WIDTH-1:0] dly_in_re,
  output logic [DATA_WIDTH-1:0] dly_in_im,
  output logic                  out_valid,
  output logic                  out_first,
  output logic [DATA_WIDTH-1:0] out_re,
  output logic [DATA_WIDTH-1:0] out_im,
  output logic                  err,
  output logic                  ovf
);

  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, FILL, BFLY, DRAIN} state_t;

  state_t                  state, state_nx;
  logic [CW-1:0]           cnt, cnt_nx;
  logic                    pending, pending_nx;
  logic                    valid_nx, first_nx, err_nx;
  logic [DATA_WIDTH-1:0]   res_re, res_im;

  logic signed [DATA_WIDTH:0] sum_re, sum_im, dif_re, dif_im;
  logic [DATA_WIDTH-1:0]      sum_re_r, sum_im_r, dif_re_r, dif_im_r;

  assign sum_re = (DATA_WIDTH+1)'($signed(dly_out_re)) + (DATA_WIDTH+1)'($signed(in_re));
  assign sum_im = (DATA_WIDTH+1)'($signed(dly_out_im)) + (DATA_WIDTH+1)'($signed(in_im));
  assign dif_re = (DATA_WIDTH+1)'($signed(dly_out_re)) - (DATA_WIDTH+1)'($signed(in_re));
  assign dif_im = (DATA_WIDTH+1)'($signed(dly_out_im)) - (DATA_WIDTH+1)'($signed(in_im));

`ifdef R2SDF_SAT_EN
  function automatic logic [DATA_WIDTH-1:0] sat(input logic signed [DATA_WIDTH:0] v);
    if (v[DATA_WIDTH] != v[DATA_WIDTH-1])
      return v[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    return v[DATA_WIDTH-1:0];
  endfunction

  function automatic logic out_of_range(input logic signed [DATA_WIDTH:0] v);
    return v[DATA_WIDTH] ^ v[DATA_WIDTH-1];
  endfunction

  logic sat_hit;

  assign sum_re_r = sat(sum_re);
  assign sum_im_r = sat(sum_im);
  assign dif_re_r = sat(dif_re);
  assign dif_im_r = sat(dif_im);
  assign sat_hit  = (state == BFLY) && in_valid &&
                    (out_of_range(sum_re) || out_of_range(sum_im) ||
                     out_of_range(dif_re) || out_of_range(dif_im));

  always_ff @(posedge clk) begin
    if (clr)          ovf <= 1'b0;
    else if (sat_hit) ovf <= 1'b1;
  end
`else
  logic unused_msbs;

  assign sum_re_r    = sum_re[DATA_WIDTH-1:0];
  assign sum_im_r    = sum_im[DATA_WIDTH-1:0];
  assign dif_re_r    = dif_re[DATA_WIDTH-1:0];
  assign dif_im_r    = dif_im[DATA_WIDTH-1:0];
  assign unused_msbs = ^{sum_re[DATA_WIDTH], sum_im[DATA_WIDTH],
                         dif_re[DATA_WIDTH], dif_im[DATA_WIDTH]};
  assign ovf         = 1'b0;
`endif

  // After BFLY the FSM always lands in FILL with differences pending; if no new
  // frame arrives on that first cycle it behaves as the first DRAIN cycle instead.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    pending_nx = pending;
    valid_nx   = 1'b0;
    first_nx   = 1'b0;
    err_nx     = 1'b0;
    dly_in_re  = '0;
    dly_in_im  = '0;
    res_re     = dly_out_re;
    res_im     = dly_out_im;
    case (state)
      IDLE: begin
        if (in_valid) begin
          dly_in_re  = in_re;
          dly_in_im  = in_im;
          state_nx   = FILL;
          cnt_nx     = cnt + CW'(1);
          pending_nx = 1'b0;
        end
      end
      FILL: begin
        if (in_valid) begin
          dly_in_re = in_re;
          dly_in_im = in_im;
          valid_nx  = pending;
          cnt_nx    = cnt + CW'(1);
          if (cnt == LAST) begin
            state_nx   = BFLY;
            pending_nx = 1'b0;
          end
        end else if (pending && cnt == '0) begin
          valid_nx   = 1'b1;
          state_nx   = DRAIN;
          cnt_nx     = cnt + CW'(1);
          pending_nx = 1'b0;
        end else begin
          err_nx     = 1'b1;
          state_nx   = IDLE;
          cnt_nx     = '0;
          pending_nx = 1'b0;
        end
      end
      BFLY: begin
        if (in_valid) begin
          dly_in_re = dif_re_r;
          dly_in_im = dif_im_r;
          res_re    = sum_re_r;
          res_im    = sum_im_r;
          valid_nx  = 1'b1;
          first_nx  = (cnt == '0);
          cnt_nx    = cnt + CW'(1);
          if (cnt == LAST) begin
            state_nx   = FILL;
            pending_nx = 1'b1;
          end
        end else begin
          err_nx     = 1'b1;
          state_nx   = IDLE;
          cnt_nx     = '0;
          pending_nx = 1'b0;
        end
      end
      DRAIN: begin
        valid_nx = 1'b1;
        err_nx   = in_valid;
        cnt_nx   = cnt + CW'(1);
        if (cnt == LAST) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= IDLE;
      cnt       <= '0;
      pending   <= 1'b0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      err       <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      pending   <= pending_nx;
      out_valid <= valid_nx;
      out_first <= first_nx;
      err       <= err_nx;
      out_re    <= res_re;
      out_im    <= res_im;
    end
  end

endmodule

// File: tb/tb_r2sdf_stage.sv
// Directed table-driven bench for r2sdf_stage wired to a DEPTH-cycle delay line model.
module tb_r2sdf_stage;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
`ifdef R2SDF_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          clr, in_valid;
  logic [DW-1:0] in_re, in_im, dly_in_re, dly_in_im, dly_out_re, dly_out_im, out_re, out_im;
  logic          out_valid, out_first, err, ovf;

  always #5 clk = ~clk;

  r2sdf_stage #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
    .dly_out_re(dly_out_re), .dly_out_im(dly_out_im),
    .dly_in_re(dly_in_re), .dly_in_im(dly_in_im),
    .out_valid(out_valid), .out_first(out_first), .out_re(out_re), .out_im(out_im),
    .err(err), .ovf(ovf)
  );

  // External delay line: DEPTH-stage shift register sharing clr.
  logic [DW-1:0] dl_re [DEPTH];
  logic [DW-1:0] dl_im [DEPTH];
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        dl_re[i] <= '0;
        dl_im[i] <= '0;
      end
    end else begin
      dl_re[0] <= dly_in_re;
      dl_im[0] <= dly_in_im;
      for (int i = 1; i < DEPTH; i++) begin
        dl_re[i] <= dl_re[i-1];
        dl_im[i] <= dl_im[i-1];
      end
    end
  end
  assign dly_out_re = dl_re[DEPTH-1];
  assign dly_out_im = dl_im[DEPTH-1];

  typedef struct {
    logic          rst;
    logic          iv;
    logic [DW-1:0] in_re, in_im;
    logic          ev, ef, ee, eo;
    logic [DW-1:0] er, ei;
  } vec_t;

  vec_t tab[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void push(bit rst, bit iv, int re, int im);
    vec_t v;
    v.rst = rst; v.iv = iv; v.in_re = DW'(re); v.in_im = DW'(im);
    v.ev = 1'b0; v.ef = 1'b0; v.ee = 1'b0; v.eo = 1'b0; v.er = '0; v.ei = '0;
    tab.push_back(v);
  endfunction

  function automatic void exp_out(int idx, bit f, int re, int im);
    vec_t v = tab[idx];
    v.ev = 1'b1; v.ef = f; v.er = DW'(re); v.ei = DW'(im);
    tab[idx] = v;
  endfunction

  function automatic void exp_err(int idx);
    vec_t v = tab[idx];
    v.ee = 1'b1;
    tab[idx] = v;
  endfunction

  function automatic void exp_ovf(int idx, bit o);
    vec_t v = tab[idx];
    v.eo = o;
    tab[idx] = v;
  endfunction

  task automatic check(string name, int idx, logic [DW-1:0] got, logic [DW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s (step %0d): got %h, expected %h", name, idx, got, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int seen, seen_re, seen_first;
    clr = 1'b1; in_valid = 1'b0; in_re = '0; in_im = '0;

    // A: single frame 1..8, then idle
    b = tab.size();
    for (int k = 0; k < 8; k++) push(k == 0, 1'b1, k + 1, 0);
    for (int k = 0; k < 7; k++) push(1'b0, 1'b0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      exp_out(b + 5 + k, k == 0, 6 + 2*k, 0);
      exp_out(b + 9 + k, 1'b0, -4, 0);
    end

    // B: back-to-back frames 1..8 and 11..18
    b = tab.size();
    for (int k = 0; k < 16; k++) push(k == 0, 1'b1, (k < 8) ? k + 1 : k + 3, 0);
    for (int k = 0; k < 7; k++) push(1'b0, 1'b0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      exp_out(b + 5 + k,  k == 0, 6 + 2*k, 0);
      exp_out(b + 9 + k,  1'b0, -4, 0);
      exp_out(b + 13 + k, k == 0, 26 + 2*k, 0);
      exp_out(b + 17 + k, 1'b0, -4, 0);
    end

    // C: in_valid drops on the 3rd sample, then a clean frame
    b = tab.size();
    push(1'b1, 1'b1, 1, 0);
    push(1'b0, 1'b1, 2, 0);
    push(1'b0, 1'b0, 0, 0);
    push(1'b0, 1'b0, 0, 0);
    for (int k = 0; k < 8; k++) push(1'b0, 1'b1, k + 1, 0);
    for (int k = 0; k < 7; k++) push(1'b0, 1'b0, 0, 0);
    exp_err(b + 3);
    for (int k = 0; k < 4; k++) begin
      exp_out(b + 9 + k,  k == 0, 6 + 2*k, 0);
      exp_out(b + 13 + k, 1'b0, -4, 0);
    end

    // D: stray in_valid on the 2nd drain cycle
    b = tab.size();
    for (int k = 0; k < 8; k++) push(k == 0, 1'b1, k + 1, 0);
    push(1'b0, 1'b0, 0, 0);
    push(1'b0, 1'b1, 16'h1234, 16'h0055);
    for (int k = 0; k < 6; k++) push(1'b0, 1'b0, 0, 0);
    exp_err(b + 10);
    for (int k = 0; k < 4; k++) begin
      exp_out(b + 5 + k, k == 0, 6 + 2*k, 0);
      exp_out(b + 9 + k, 1'b0, -4, 0);
    end

    // E: overflow corners
    b = tab.size();
    push(1'b1, 1'b1, 16'h7FFF, 16'h8000);
    for (int k = 1; k < 4; k++) push(1'b0, 1'b1, 0, 0);
    push(1'b0, 1'b1, 16'h7FFF, 16'h7FFF);
    for (int k = 5; k < 8; k++) push(1'b0, 1'b1, 0, 0);
    for (int k = 0; k < 7; k++) push(1'b0, 1'b0, 0, 0);
    exp_out(b + 5, 1'b1, SAT ? 16'h7FFF : 16'hFFFE, 16'hFFFF);
    for (int k = 1; k < 4; k++) exp_out(b + 5 + k, 1'b0, 0, 0);
    exp_out(b + 9, 1'b0, 0, SAT ? 16'h8000 : 16'h0001);
    for (int k = 1; k < 4; k++) exp_out(b + 9 + k, 1'b0, 0, 0);
    for (int k = 5; k < 15; k++) exp_ovf(b + k, SAT);

    foreach (tab[i]) begin
      if (tab[i].rst) begin
        clr = 1'b1;
        in_valid = 1'b0;
      end
      @(negedge clk);
      clr = 1'b0;
      check("out_valid", i, DW'(out_valid), DW'(tab[i].ev));
      check("out_first", i, DW'(out_first), DW'(tab[i].ef));
      check("err", i, DW'(err), DW'(tab[i].ee));
      check("ovf", i, DW'(ovf), DW'(tab[i].eo));
      if (tab[i].ev || tab[i].rst) begin
        check("out_re", i, out_re, tab[i].er);
        check("out_im", i, out_im, tab[i].ei);
      end
      in_valid = tab[i].iv;
      in_re    = tab[i].in_re;
      in_im    = tab[i].in_im;
    end

    // F: clr on cycle 6 of a frame, then restart latency
    clr = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    clr = 1'b0; in_im = '0;
    for (int c = 0; c < 7; c++) begin
      if (c == 6) begin
        check("pre_clr_valid", c, DW'(out_valid), 16'd1);
        check("pre_clr_sum", c, out_re, 16'd8);
      end
      in_valid = 1'b1;
      in_re    = DW'(c + 1);
      clr      = (c == 6);
      @(negedge clk);
    end
    clr = 1'b0; in_valid = 1'b0;
    check("clr_valid", 7, DW'(out_valid), 16'd0);
    check("clr_first", 7, DW'(out_first), 16'd0);
    check("clr_err", 7, DW'(err), 16'd0);
    check("clr_re", 7, out_re, 16'd0);
    check("clr_im", 7, out_im, 16'd0);
    for (int c = 8; c < 13; c++) begin
      @(negedge clk);
      check("post_clr_valid", c, DW'(out_valid), 16'd0);
      check("post_clr_err", c, DW'(err), 16'd0);
    end

    seen = -1; seen_re = 0; seen_first = 0;
    in_valid = 1'b1; in_re = 16'd1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1 && seen < 0) begin
        seen       = c;
        seen_re    = int'(out_re);
        seen_first = int'(out_first);
      end
      if (c < 8) begin
        in_valid = 1'b1;
        in_re    = DW'(c + 1);
      end else begin
        in_valid = 1'b0;
      end
    end
    check("restart_latency", 0, DW'(seen), 16'd5);
    check("restart_first_sum", 0, DW'(seen_re), 16'd6);
    check("restart_first_flag", 0, DW'(seen_first), 16'd1);
    repeat (6) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
